// File: rtl/transfer_pkg.sv
// Shared definitions for the memory-to-memory transfer datapath:
// address widths for the A- and B-side counters and the controller.
package transfer_pkg;

    localparam int unsigned ADDR_W_A = 2;
    localparam int unsigned ADDR_W_B = 2;

endpackage : transfer_pkg

// File: rtl/counter_b.sv
// Memory-B word address counter: increments on IncB, wraps modulo 2^WIDTH,
// clears asynchronously on Reset. The A side instantiates this same module.
module counter_b
    import transfer_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W_B
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             IncB,
    output logic [WIDTH-1:0] AddrB
);

    logic [WIDTH-1:0] cnt;

    // Overflow past 2^WIDTH-1 is discarded, giving the wrap to 0.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (IncB) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign AddrB = cnt;

endmodule : counter_b

// File: tb/tb_counter_b.sv
// Bench for counter_b: vector table for the default width plus hand-written
// sequences for asynchronous reset and a WIDTH=3 instance.
module tb_counter_b;

    typedef struct {
        string      name;
        logic       rst;
        logic       inc;
        logic [1:0] expAddr;
    } vec_t;

    logic       clock;
    logic       Reset;
    logic       IncB;
    logic [1:0] AddrB;

    logic       rstW;
    logic       incW;
    logic [2:0] addrW;

    int errors;
    int checks;

    counter_b dut (
        .clock (clock),
        .Reset (Reset),
        .IncB  (IncB),
        .AddrB (AddrB)
    );

    counter_b #(.WIDTH(3)) dutWide (
        .clock (clock),
        .Reset (rstW),
        .IncB  (incW),
        .AddrB (addrW)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge happen, sample 1 time unit later.
    task automatic stepB(input logic rst, input logic inc);
        @(negedge clock);
        Reset = rst;
        IncB  = inc;
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        errors = 0;
        checks = 0;
        Reset  = 1'b1;
        IncB   = 1'b0;
        rstW   = 1'b1;
        incW   = 1'b0;

        vecs = '{
            '{"t1 reset edge",      1'b1, 1'b0, 2'd0},
            '{"t1 idle edge 1",     1'b0, 1'b0, 2'd0},
            '{"t1 idle edge 2",     1'b0, 1'b0, 2'd0},
            '{"t2 inc to 1",        1'b0, 1'b1, 2'd1},
            '{"t2 hold 1",          1'b0, 1'b0, 2'd1},
            '{"t3 inc to 2",        1'b0, 1'b1, 2'd2},
            '{"t3 inc to 3",        1'b0, 1'b1, 2'd3},
            '{"t3 hold 3",          1'b0, 1'b0, 2'd3},
            '{"t3 wrap to 0",       1'b0, 1'b1, 2'd0},
            '{"t5 rst+inc edge 1",  1'b1, 1'b1, 2'd0},
            '{"t5 rst+inc edge 2",  1'b1, 1'b1, 2'd0},
            '{"t5 release inc 1",   1'b0, 1'b1, 2'd1},
            '{"t5 release inc 2",   1'b0, 1'b1, 2'd2}
        };

        #1;
        check("reset state", 8'(AddrB), 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            stepB(vecs[i].rst, vecs[i].inc);
            check(vecs[i].name, 8'(AddrB), 8'(vecs[i].expAddr));
        end

        // Asynchronous reset while the clock is low, from a count of 1.
        stepB(1'b1, 1'b0);
        stepB(1'b0, 1'b1);
        check("t4 count to 1", 8'(AddrB), 8'd1);
        @(negedge clock);
        Reset = 1'b1;
        IncB  = 1'b0;
        #1;
        check("t4 async clear", 8'(AddrB), 8'd0);
        @(posedge clock);
        #1;
        check("t4 held in reset", 8'(AddrB), 8'd0);
        stepB(1'b0, 1'b1);
        check("t4 release inc", 8'(AddrB), 8'd1);
        stepB(1'b0, 1'b0);
        check("t4 hold after release", 8'(AddrB), 8'd1);

        // WIDTH=3 instance: 9 consecutive increments wrap through 0 to 1.
        @(negedge clock);
        rstW = 1'b0;
        #1;
        check("t6 wide reset state", 8'(addrW), 8'd0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            incW = 1'b1;
            @(posedge clock);
            #1;
            check($sformatf("t6 wide inc %0d", i), 8'(addrW), 8'(i % 8));
        end
        @(negedge clock);
        incW = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter_b
